angle_spi_scanner: RTL



---
 rtl/angle_spi_scanner.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/angle_spi_scanner.sv
// rtl/angle_spi_scanner.sv - round-robin SPI angle-sensor scanner with an Avalon-MM register file
//
// Scans the sensors enabled in the mask one at a time over a shared SCK/MOSI/MISO bus,
// with one active-low select per sensor, and keeps the latest word from each sensor.
//
// Ports:
//   clock, reset_n       system clock, asynchronous active-low reset
//   address/read/readdata/write/writedata
//                        Avalon-MM slave, zero wait states
//                        0x00 control: bit0 enable, bit1 continuous, bit2 write-1 start pulse
//                        0x01 mask, 0x02 status: bit0 busy, [15:8] parity errors, [31:16] frame count
//                        0x10+i angle[i]
//   angle_sck            SPI clock, idle low
//   angle_mosi           SPI data out, changes on SCK rising edge
//   angle_miso           SPI data in, sampled where SCK falls
//   angle_ss_n_o         per-sensor active-low selects
//
// Optional build macro PARITY_CHECK_EN: reject received words with odd parity and count
// them in status[15:8] (saturating, cleared by any status write).
module angle_spi_scanner #(
    parameter int          NUM_SENSORS = 9,
    parameter int          DATA_WIDTH  = 16,
    parameter int          CLK_DIV     = 10,
    parameter logic [31:0] CMD_WORD    = 32'h0000_FFFF
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [7:0]             address,
    input  logic                   read,
    output logic [31:0]            readdata,
    input  logic                   write,
    input  logic [31:0]            writedata,
    output logic                   angle_sck,
    output logic                   angle_mosi,
    input  logic                   angle_miso,
    output logic [NUM_SENSORS-1:0] angle_ss_n_o
);
    // index must be able to hold NUM_SENSORS itself: that value marks "pass finished"
    localparam int IW = $clog2(NUM_SENSORS + 1);
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]         DIV_LAST = CW'(CLK_DIV - 1);
    // GAP is one cycle short; the FIND cycle completes the 2*CLK_DIV deselect time
    localparam logic [CW-1:0]         GAP_LAST = CW'(2 * CLK_DIV - 2);
    localparam logic [BW-1:0]         BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] CMD      = DATA_WIDTH'(CMD_WORD);

    typedef enum logic [2:0] {S_IDLE, S_FIND, S_SELECT, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           index_q, index_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic                    sck_q, sck_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [DATA_WIDTH-1:0]   rx_q, rx_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic                    enable_q, cont_q;
    logic [NUM_SENSORS-1:0]  mask_q;
    logic [DATA_WIDTH-1:0]   angle_q [NUM_SENSORS];

    logic                    ctrl_wr, mask_wr, start_wr;
    logic                    hold_done, angle_we, busy, sel_active;
    logic                    found;
    logic [IW-1:0]           found_idx, first_idx;
    logic [7:0]              err_rd;
    logic                    unused_wdata;

    assign ctrl_wr      = write && (address == 8'h00);
    assign mask_wr      = write && (address == 8'h01);
    assign start_wr     = ctrl_wr && writedata[2];
    assign busy         = (state_q != S_IDLE);
    assign sel_active   = (state_q == S_SELECT) || (state_q == S_SHIFT) || (state_q == S_HOLD);
    assign unused_wdata = ^writedata;

    // found: lowest enabled sensor at or above index; first_idx: lowest enabled sensor overall
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        first_idx = '0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_idx = IW'(i);
                if (IW'(i) >= index_q) begin
                    found     = 1'b1;
                    found_idx = IW'(i);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        sck_d       = sck_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        frame_cnt_d = frame_cnt_q;
        hold_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((enable_q && cont_q) || (start_wr && writedata[0])) begin
                    state_d = S_FIND;
                    index_d = '0;
                end
            end
            S_FIND: begin
                if (mask_q == '0) begin
                    state_d = S_IDLE;
                end else if (!found) begin
                    // pass complete: it counts even if enable dropped during the last frame
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (enable_q && cont_q) begin
                        index_d = first_idx;
                        cnt_d   = '0;
                        tx_d    = CMD;
                        state_d = S_SELECT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (!enable_q) begin
                    state_d = S_IDLE;
                end else begin
                    index_d = found_idx;
                    cnt_d   = '0;
                    tx_d    = CMD;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (sck_q) begin
                        sck_d = 1'b0;
                        rx_d  = {rx_q[DATA_WIDTH-2:0], angle_miso};
                    end else if (bit_q == BIT_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        // the MSB is already on MOSI from SELECT, so the first rise keeps it
                        sck_d = 1'b1;
                        tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DIV_LAST) begin
                    cnt_d     = '0;
                    hold_done = 1'b1;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    index_d = index_q + 1'b1;
                    state_d = S_FIND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef PARITY_CHECK_EN
    logic [7:0] err_q;
    logic       parity_ok;
    logic       status_wr;

    assign status_wr = write && (address == 8'h02);
    assign parity_ok = ~(^rx_q);
    assign angle_we  = hold_done && parity_ok;
    assign err_rd    = err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 8'd0;
        end else if (status_wr) begin
            err_q <= 8'd0;
        end else if (hold_done && !parity_ok && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end
`else
    assign angle_we = hold_done;
    assign err_rd   = 8'd0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            cnt_q       <= '0;
            bit_q       <= '0;
            sck_q       <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            frame_cnt_q <= 16'd0;
            enable_q    <= 1'b0;
            cont_q      <= 1'b0;
            mask_q      <= '1;
            for (int i = 0; i < NUM_SENSORS; i++) angle_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sck_q       <= sck_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            frame_cnt_q <= frame_cnt_d;
            if (ctrl_wr) begin
                enable_q <= writedata[0];
                cont_q   <= writedata[1];
            end
            if (mask_wr) mask_q <= writedata[NUM_SENSORS-1:0];
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (angle_we && (index_q == IW'(i))) angle_q[i] <= rx_q;
            end
        end
    end

    assign angle_sck  = sck_q;
    assign angle_mosi = sel_active ? tx_q[DATA_WIDTH-1] : 1'b0;

    always_comb begin
        angle_ss_n_o = '1;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (sel_active && (index_q == IW'(i))) angle_ss_n_o[i] = 1'b0;
        end
    end

    // registered angle values are read, so a same-cycle update returns the old word
    always_comb begin
        readdata = 32'd0;
        if (read) begin
            if (address == 8'h00)      readdata = {30'd0, cont_q, enable_q};
            else if (address == 8'h01) readdata = 32'(mask_q);
            else if (address == 8'h02) readdata = {frame_cnt_q, err_rd, 7'd0, busy};
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (address == 8'(16 + i)) readdata = 32'(angle_q[i]);
            end
        end
    end
endmodule
